parking_sensor_emulator: RTL

- Produces the a/b beam-sensor waveforms that the parking lot occupancy counter consumes. It is the transmitter side of the same two-sensor protocol.
- Accepts one "car enters" or "car exits" command through a valid/ready handshake. It then drives the matching four-phase Gray sequence on a and b, with programmable dwell per phase.
- Keeps a reference occupancy count and rejects impossible commands.
- Used in benches and board self-test to drive the counter and cross-check its occupancy output.

---
 rtl/parking_sensor_emulator.sv | 97 +++++++++
 1 files changed

// File: rtl/parking_sensor_emulator.sv
// parking_sensor_emulator: drives a/b beam-sensor Gray sequences for enter/exit commands and tracks a reference occupancy
module parking_sensor_emulator #(
  parameter int DWELL   = 10,
  parameter int GAP     = 10,
  parameter int MAX_OCC = 15,
  parameter int OCC_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  output logic             cmd_ready,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             cmd_reject,
  output logic [OCC_W-1:0] occupancy
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PH1  = 3'd1;
  localparam logic [2:0] PH2  = 3'd2;
  localparam logic [2:0] PH3  = 3'd3;
  localparam logic [2:0] GAPS = 3'd4;
  localparam logic [15:0] dw_ld = 16'(DWELL - 1);
  localparam logic [15:0] gp_ld = 16'(GAP - 1);
  localparam logic [OCC_W-1:0] occ_max = OCC_W'(MAX_OCC);
  logic [2:0] st, st_n;
  logic [15:0] cnt, cnt_n;
  logic dir, dir_n, done_n, rej_n, a_n, b_n, accept, illegal, last;
  logic [OCC_W-1:0] occ_n;
  // next state, dwell reload on every phase entry, and the pattern of the state being entered
  always_comb begin
    accept = cmd_valid && cmd_ready;
    illegal = cmd_dir ? occupancy == '0 : occupancy == occ_max;
    last = cnt == '0;
    st_n = st;
    cnt_n = (st != IDLE && !last) ? cnt - 16'd1 : cnt;
    dir_n = dir;
    done_n = 1'b0;
    occ_n = occupancy;
    rej_n = st == IDLE && accept && illegal;
    case (st)
      IDLE: if (accept && !illegal) begin
        st_n = PH1;
        cnt_n = dw_ld;
        dir_n = cmd_dir;
      end
      PH1: if (last) begin
        st_n = PH2;
        cnt_n = dw_ld;
      end
      PH2: if (last) begin
        st_n = PH3;
        cnt_n = dw_ld;
      end
      PH3: if (last) begin
        st_n = GAPS;
        cnt_n = gp_ld;
      end
      GAPS: if (last) begin
        st_n = IDLE;
        done_n = 1'b1;
        occ_n = dir ? occupancy - OCC_W'(1) : occupancy + OCC_W'(1);
      end
      default: st_n = IDLE;
    endcase
    a_n = (st_n == PH1 && !dir_n) || st_n == PH2 || (st_n == PH3 && dir_n);
    b_n = (st_n == PH1 && dir_n) || st_n == PH2 || (st_n == PH3 && !dir_n);
  end
  // register state and every output; reset abandons any sequence in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      dir <= 1'b0;
      a <= 1'b0;
      b <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cmd_reject <= 1'b0;
      occupancy <= '0;
      cmd_ready <= 1'b1;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      dir <= dir_n;
      a <= a_n;
      b <= b_n;
      busy <= st_n != IDLE;
      done <= done_n;
      cmd_reject <= rej_n;
      occupancy <= occ_n;
      cmd_ready <= st_n == IDLE;
    end
  end
endmodule
